// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and helpers for load_store_unit
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory bundle of load_store_unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_address;
    logic [63:0] req_data;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_address, req_data, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_fault,
        input  mem_read, mem_write, mem_address, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_address, req_data, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_fault,
        output mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - low byte-lane extract with sign or zero extension to 64 bits
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [63:0] result_o
);

    always_comb begin
        result_o = rdata_i;
        case (size_i)
            SZ_BYTE: result_o = {{56{signed_i & rdata_i[7]}},  rdata_i[7:0]};
            SZ_HALF: result_o = {{48{signed_i & rdata_i[15]}}, rdata_i[15:0]};
            SZ_WORD: result_o = {{32{signed_i & rdata_i[31]}}, rdata_i[31:0]};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store FSM with read-modify-write for sub-word stores
// Optional alignment/range faulting is enabled by defining LSU_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int SIZE = 256
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    load_store_unit_if.slave  bus
);

`ifdef LSU_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif
    localparam logic [63:0] LAST_ADDR = 64'(SIZE - 8);

    lsu_state_e  state_q, state_d;
    logic        write_q, signed_q, fault_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q, data_q, merge_q, resp_data_q;
    logic [63:0] load_ext, merge_d, align_mask;
    logic        accept, fault_d;

    assign accept     = bus.req_valid && (state_q == ST_IDLE);
    assign align_mask = 64'(size_bytes(bus.req_size)) - 64'd1;
    assign fault_d    = CHECK_EN && (((bus.req_address & align_mask) != 64'd0)
                                     || (bus.req_address > LAST_ADDR));

    lsu_extend u_extend (
        .rdata_i  (bus.mem_rdata),
        .size_i   (size_q),
        .signed_i (signed_q),
        .result_o (load_ext)
    );

    always_comb begin
        merge_d = bus.mem_rdata;
        case (size_q)
            SZ_BYTE: merge_d = {bus.mem_rdata[63:8],  data_q[7:0]};
            SZ_HALF: merge_d = {bus.mem_rdata[63:16], data_q[15:0]};
            SZ_WORD: merge_d = {bus.mem_rdata[63:32], data_q[31:0]};
            default: merge_d = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (fault_d)                     state_d = ST_RESP;
                    else if (!bus.req_write)         state_d = ST_LOAD;
                    else if (bus.req_size == SZ_DOUBLE) state_d = ST_WRITE;
                    else                             state_d = ST_MERGE;
                end
            end
            ST_LOAD:  state_d = ST_RESP;
            ST_MERGE: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            fault_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            addr_q      <= '0;
            data_q      <= '0;
            merge_q     <= '0;
            resp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q     <= bus.req_write;
                signed_q    <= bus.req_signed;
                size_q      <= bus.req_size;
                addr_q      <= bus.req_address;
                data_q      <= bus.req_data;
                fault_q     <= fault_d;
                resp_data_q <= '0;
            end
            if (state_q == ST_LOAD) resp_data_q <= load_ext;
            if (state_q == ST_MERGE) merge_q <= merge_d;
        end
    end

    // Outputs decode straight from state so an async reset drops the strobes at once.
    always_comb begin
        bus.req_ready   = (state_q == ST_IDLE);
        bus.resp_valid  = (state_q == ST_RESP);
        bus.resp_data   = (state_q == ST_RESP && !write_q) ? resp_data_q : 64'd0;
        bus.resp_fault  = (state_q == ST_RESP) && fault_q;
        bus.mem_read    = (state_q == ST_LOAD) || (state_q == ST_MERGE);
        bus.mem_write   = (state_q == ST_WRITE);
        bus.mem_address = (bus.mem_read || bus.mem_write) ? addr_q : 64'd0;
        bus.mem_wdata   = 64'd0;
        if (state_q == ST_WRITE)
            bus.mem_wdata = (size_q == SZ_DOUBLE) ? data_q : merge_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a byte-array model
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit #(.SIZE(256)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic        clr = 1'b1;
    logic        pk_en = 1'b0;
    logic [7:0]  pk_addr = '0;
    logic [63:0] pk_data = '0;
    int          wr_count = 0;
    int          both_cnt = 0;
    int          total = 0;
    int          bad = 0;

    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 8; i++)
            bus.mem_rdata[i*8 +: 8] = mem[8'(bus.mem_address[7:0] + 8'(i))];
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (bus.mem_write) begin
            for (int i = 0; i < 8; i++) mem[8'(bus.mem_address[7:0] + 8'(i))] <= bus.mem_wdata[i*8 +: 8];
            wr_count <= wr_count + 1;
        end else if (pk_en) begin
            for (int i = 0; i < 8; i++) mem[8'(pk_addr + 8'(i))] <= pk_data[i*8 +: 8];
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz, input logic sg);
        int n = nbytes(sz);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = v + (64'(ref_mem[int'((a + 64'(i)) & 64'hFF)]) << (8 * i));
        if (sg && n < 8 && v[8*n-1]) v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    function automatic void model_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[int'((a + 64'(i)) & 64'hFF)] = 8'((d >> (8 * i)) & 64'hFF);
    endfunction

    function automatic logic model_fault(input logic [63:0] a, input logic [1:0] sz);
`ifdef LSU_CHECK_EN
        return ((a % 64'(nbytes(sz))) != 0) || (a > 64'd248);
`else
        return (a != a);
`endif
    endfunction

    task automatic poke(input logic [7:0] a, input logic [63:0] d);
        @(negedge clk);
        pk_en = 1'b1; pk_addr = a; pk_data = d;
        for (int i = 0; i < 8; i++) ref_mem[8'(a + 8'(i))] = d[i*8 +: 8];
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [63:0] a,
                          input logic [63:0] d, output logic [63:0] rdata, output logic flt,
                          output int lat, output int nrd, output int nwr, output logic [63:0] wdat);
        bit found = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
        bus.req_address = a; bus.req_data = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rdata = '0; flt = 1'b0; lat = -1; nrd = 0; nwr = 0; wdat = '0;
        for (int c = 1; c <= 8 && !found; c++) begin
            @(negedge clk);
            if (bus.mem_read) nrd++;
            if (bus.mem_write) begin nwr++; wdat = bus.mem_wdata; end
            if (bus.mem_read && bus.mem_write) both_cnt++;
            if (bus.resp_valid) begin
                found = 1; lat = c; rdata = bus.resp_data; flt = bus.resp_fault;
            end
        end
    endtask

    task automatic test_reset();
        total += 8;
        if (bus.req_ready   !== 1'b1)  begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
        if (bus.resp_valid  !== 1'b0)  begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
        if (bus.resp_data   !== 64'd0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", bus.resp_data); end
        if (bus.resp_fault  !== 1'b0)  begin bad++; $display("FAIL reset_resp_fault got=%b exp=0", bus.resp_fault); end
        if (bus.mem_read    !== 1'b0)  begin bad++; $display("FAIL reset_mem_read got=%b exp=0", bus.mem_read); end
        if (bus.mem_write   !== 1'b0)  begin bad++; $display("FAIL reset_mem_write got=%b exp=0", bus.mem_write); end
        if (bus.mem_address !== 64'd0) begin bad++; $display("FAIL reset_mem_address got=%h exp=0", bus.mem_address); end
        if (bus.mem_wdata   !== 64'd0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
    endtask

    task automatic test_byte_load();
        logic [63:0] r, wd; logic f; int lat, nrd, nwr;
        poke(8'd8, 64'h0000_0000_0000_7F80);
        do_req(1'b0, SZ_BYTE, 1'b1, 64'd8, '0, r, f, lat, nrd, nwr, wd);
        total += 3;
        if (r !== 64'hFFFF_FFFF_FFFF_FF80) begin bad++; $display("FAIL lb_signed got=%h exp=ffffffffffffff80", r); end
        if (lat !== 2) begin bad++; $display("FAIL lb_latency got=%0d exp=2", lat); end
        if (nrd !== 1 || nwr !== 0) begin bad++; $display("FAIL lb_strobes rd=%0d wr=%0d exp=1/0", nrd, nwr); end
        do_req(1'b0, SZ_BYTE, 1'b0, 64'd8, '0, r, f, lat, nrd, nwr, wd);
        total++;
        if (r !== 64'h80) begin bad++; $display("FAIL lb_unsigned got=%h exp=80", r); end
        do_req(1'b0, SZ_HALF, 1'b1, 64'd8, '0, r, f, lat, nrd, nwr, wd);
        total++;
        if (r !== 64'h7F80) begin bad++; $display("FAIL lh_signed got=%h exp=7f80", r); end
    endtask

    task automatic test_store_double();
        logic [63:0] r, wd; logic f; int lat, nrd, nwr;
        do_req(1'b1, SZ_DOUBLE, 1'b0, 64'd16, 64'h1122334455667788, r, f, lat, nrd, nwr, wd);
        model_store(64'd16, SZ_DOUBLE, 64'h1122334455667788);
        total += 4;
        if (lat !== 2) begin bad++; $display("FAIL sd_latency got=%0d exp=2", lat); end
        if (nrd !== 0 || nwr !== 1) begin bad++; $display("FAIL sd_strobes rd=%0d wr=%0d exp=0/1", nrd, nwr); end
        if (wd !== 64'h1122334455667788) begin bad++; $display("FAIL sd_wdata got=%h exp=1122334455667788", wd); end
        if (r !== 64'd0) begin bad++; $display("FAIL sd_resp_data got=%h exp=0", r); end
        do_req(1'b0, SZ_DOUBLE, 1'b1, 64'd16, '0, r, f, lat, nrd, nwr, wd);
        total++;
        if (r !== 64'h1122334455667788) begin bad++; $display("FAIL ld_after_sd got=%h exp=1122334455667788", r); end
    endtask

    task automatic test_subword_store();
        logic [63:0] r, wd; logic f; int lat, nrd, nwr;
        poke(8'd24, 64'hAAAA_AAAA_AAAA_AAAA);
        do_req(1'b1, SZ_HALF, 1'b0, 64'd24, 64'h1234_5678_9ABC_BEEF, r, f, lat, nrd, nwr, wd);
        model_store(64'd24, SZ_HALF, 64'h1234_5678_9ABC_BEEF);
        total += 3;
        if (lat !== 3) begin bad++; $display("FAIL sh_latency got=%0d exp=3", lat); end
        if (nrd !== 1 || nwr !== 1) begin bad++; $display("FAIL sh_strobes rd=%0d wr=%0d exp=1/1", nrd, nwr); end
        if (wd !== 64'hAAAA_AAAA_AAAA_BEEF) begin bad++; $display("FAIL sh_wdata got=%h exp=aaaaaaaaaaaabeef", wd); end
    endtask

    task automatic test_reset_abort();
        int cnt0;
        bit diff = 0;
        poke(8'd32, 64'h0102_0304_0506_0708);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SZ_BYTE; bus.req_signed = 1'b0;
        bus.req_address = 64'd32; bus.req_data = 64'hFF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.mem_read !== 1'b1) begin bad++; $display("FAIL abort_merge_read got=%b exp=1", bus.mem_read); end
        cnt0 = wr_count;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0)
            begin bad++; $display("FAIL abort_strobes rd=%b wr=%b exp=0/0", bus.mem_read, bus.mem_write); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 32; i < 40; i++) if (mem[i] !== ref_mem[i]) diff = 1;
        total += 3;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", bus.req_ready); end
        if (wr_count !== cnt0) begin bad++; $display("FAIL abort_writes got=%0d exp=%0d", wr_count, cnt0); end
        if (diff) begin bad++; $display("FAIL abort_memory got=changed exp=unchanged"); end
    endtask

`ifdef LSU_CHECK_EN
    task automatic test_faults();
        logic [63:0] r, wd; logic f; int lat, nrd, nwr;
        do_req(1'b0, SZ_WORD, 1'b0, 64'd6, '0, r, f, lat, nrd, nwr, wd);
        total += 4;
        if (f !== 1'b1) begin bad++; $display("FAIL flt_misaligned got=%b exp=1", f); end
        if (lat !== 1) begin bad++; $display("FAIL flt_latency got=%0d exp=1", lat); end
        if (nrd !== 0 || nwr !== 0) begin bad++; $display("FAIL flt_strobes rd=%0d wr=%0d exp=0/0", nrd, nwr); end
        if (r !== 64'd0) begin bad++; $display("FAIL flt_data got=%h exp=0", r); end
        do_req(1'b0, SZ_DOUBLE, 1'b0, 64'd252, '0, r, f, lat, nrd, nwr, wd);
        total++;
        if (f !== 1'b1) begin bad++; $display("FAIL flt_range got=%b exp=1", f); end
        do_req(1'b0, SZ_DOUBLE, 1'b0, 64'd248, '0, r, f, lat, nrd, nwr, wd);
        total++;
        if (f !== 1'b0) begin bad++; $display("FAIL flt_last_ok got=%b exp=0", f); end
    endtask
`endif

    task automatic test_random();
        logic [63:0] r, wd, a, d, exp_r; logic f, w, sg, exp_f; logic [1:0] sz; int lat, nrd, nwr, exp_lat;
        for (int k = 0; k < 32; k++) poke(8'(k * 8), {$urandom, $urandom});
        for (int it = 0; it < 60; it++) begin
            w = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom); d = {$urandom, $urandom};
`ifdef LSU_CHECK_EN
            a = 64'($urandom_range(0, 255));
`else
            a = 64'($urandom_range(0, 248));
`endif
            if ($urandom_range(0, 1) == 1) a = a - (a % 64'(nbytes(sz)));
            exp_f = model_fault(a, sz);
            exp_r = (w || exp_f) ? 64'd0 : model_load(a, sz, sg);
            exp_lat = exp_f ? 1 : (!w || sz == SZ_DOUBLE) ? 2 : 3;
            do_req(w, sz, sg, a, d, r, f, lat, nrd, nwr, wd);
            if (w && !exp_f) model_store(a, sz, d);
            total += 4;
            if (r !== exp_r) begin bad++; $display("FAIL rnd_data it=%0d got=%h exp=%h", it, r, exp_r); end
            if (f !== exp_f) begin bad++; $display("FAIL rnd_fault it=%0d got=%b exp=%b", it, f, exp_f); end
            if (lat !== exp_lat) begin bad++; $display("FAIL rnd_latency it=%0d got=%0d exp=%0d", it, lat, exp_lat); end
            if (nwr !== ((w && !exp_f) ? 1 : 0)) begin bad++; $display("FAIL rnd_writes it=%0d got=%0d exp=%0d", it, nwr, (w && !exp_f) ? 1 : 0); end
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        logic [63:0] exp_q[$];
        logic [63:0] e;
        int acc = 0, got = 0;
        bit renew = 1;
        for (int c = 0; c < 40 && (acc < 3 || got < 3); c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
                got++;
                total++;
                if (bus.resp_data !== e) begin bad++; $display("FAIL b2b_data n=%0d got=%h exp=%h", got, bus.resp_data, e); end
            end
            if (acc >= 3) bus.req_valid = 1'b0;
            else begin
                if (renew) begin
                    bus.req_write = 1'b0; bus.req_size = 2'($urandom); bus.req_signed = 1'($urandom);
                    bus.req_address = 64'($urandom_range(0, 31) * 8); bus.req_data = '0;
                    renew = 0;
                end
                bus.req_valid = 1'b1;
                if (bus.req_ready) begin
                    acc_cyc.push_back(c);
                    exp_q.push_back(model_load(bus.req_address, bus.req_size, bus.req_signed));
                    acc++; renew = 1;
                end
            end
        end
        bus.req_valid = 1'b0;
        total += 3;
        if (got !== 3) begin bad++; $display("FAIL b2b_responses got=%0d exp=3", got); end
        if (acc_cyc.size() < 3) begin bad++; bad++; $display("FAIL b2b_spacing got=%0d_accepts exp=3", acc_cyc.size()); end
        else begin
            if (acc_cyc[1] - acc_cyc[0] !== 3) begin bad++; $display("FAIL b2b_spacing1 got=%0d exp=3", acc_cyc[1] - acc_cyc[0]); end
            if (acc_cyc[2] - acc_cyc[1] !== 3) begin bad++; $display("FAIL b2b_spacing2 got=%0d exp=3", acc_cyc[2] - acc_cyc[1]); end
        end
    endtask

    task automatic test_memory_image();
        int nbad = 0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
        total += 2;
        if (nbad !== 0) begin bad++; $display("FAIL mem_image got=%0d_bytes_differ exp=0", nbad); end
        if (both_cnt !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = SZ_BYTE; bus.req_signed = 1'b0;
        bus.req_address = '0; bus.req_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_byte_load();
        test_store_double();
        test_subword_store();
        test_reset_abort();
`ifdef LSU_CHECK_EN
        test_faults();
`endif
        test_random();
        test_back_to_back();
        test_memory_image();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
